// File: rtl/adder_serial_nbit_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_serial_nbit_if
// Description : Start/busy/done handshake and operand/result bus for the
//               digit-serial adder/subtractor.
// Revision    : 1.0
// ============================================================================
interface adder_serial_nbit_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic             i_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_sub, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_sub, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_cout, o_ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : adder_serial_nbit
// Description : Multi-cycle N-bit adder/subtractor, DIGIT bits per clock with a
//               registered inter-digit carry; reports carry-out and overflow.
// Revision    : 1.0
// ============================================================================
module adder_serial_nbit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  adder_serial_nbit_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Operands shift right each digit, so the active digit is always bits [DIGIT-1:0].
  always_comb begin
    w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    w_cmsb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
    w_last = (r_cnt == C_LAST);
    w_res_next = r_res;
    for (int k = 0; k < NDIG; k++) begin
      if (r_cnt == CW'(k)) begin
        w_res_next[k*DIGIT +: DIGIT] = w_dsum[DIGIT-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub | bus.i_cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_dsum[DIGIT];
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CW'(1);
          // Visible results only change once the last digit is in.
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_dsum[DIGIT];
            r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = (r_state == S_DONE);
  assign bus.o_sum  = r_sum;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_adder_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_serial_nbit
// Description : Scoreboard bench for adder_serial_nbit, DIGIT=4 and DIGIT=16.
// Revision    : 1.0
// ============================================================================
module tb_adder_serial_nbit;
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  res_t q4[$];
  res_t q16[$];

  always #5 clk = ~clk;

  adder_serial_nbit_if #(.WIDTH(16)) bus4();
  adder_serial_nbit_if #(.WIDTH(16)) bus16();

  adder_serial_nbit #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4)
  );
  adder_serial_nbit #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus16)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [16:0] f;
    logic [15:0] bb;
    res_t r;
    bb = sub ? ~b : b;
    f = {1'b0, a} + {1'b0, bb} + {16'd0, (sub | cin)};
    r.sum  = f[15:0];
    r.cout = f[16];
    r.ovf  = (a[15] == bb[15]) && (f[15] != a[15]);
    return r;
  endfunction

  function automatic res_t observed(input bit s);
    return s ? {bus16.o_sum, bus16.o_cout, bus16.o_ovf}
             : {bus4.o_sum, bus4.o_cout, bus4.o_ovf};
  endfunction

  task automatic drive(input bit s, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic st);
    if (s) begin
      bus16.i_a = a; bus16.i_b = b; bus16.i_cin = cin; bus16.i_sub = sub; bus16.i_start = st;
    end else begin
      bus4.i_a = a; bus4.i_b = b; bus4.i_cin = cin; bus4.i_sub = sub; bus4.i_start = st;
    end
  endtask

  // Start one op from IDLE; operands are scrambled right after the accepting edge.
  task automatic issue(input bit s, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    @(negedge clk);
    drive(s, a, b, cin, sub, 1'b1);
    if (s) q16.push_back(model(a, b, cin, sub));
    else   q4.push_back(model(a, b, cin, sub));
    @(negedge clk);
    drive(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic wait_done(input bit s, output int lat, output res_t got, output bit held);
    res_t prev;
    logic dn;
    prev = observed(s);
    held = 1'b1;
    got  = '0;
    lat  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      dn = s ? bus16.o_done : bus4.o_done;
      if (dn) begin
        got = observed(s);
        lat = i;
        break;
      end
      if (observed(s) !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus4.o_busy, bus4.o_done, observed(1'b0)} !== 20'd0) begin
      failures++;
      $display("FAIL reset_dut4: got %h required 0", {bus4.o_busy, bus4.o_done, observed(1'b0)});
    end
    checks++;
    if ({bus16.o_busy, bus16.o_done, observed(1'b1)} !== 20'd0) begin
      failures++;
      $display("FAIL reset_dut16: got %h required 0", {bus16.o_busy, bus16.o_done, observed(1'b1)});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0000, 16'h0007, 16'h0001};
    logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    res_t        fixed [4] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                               {16'hFFFE, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1}};
    res_t exp, got;
    int   lat;
    bit   held;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, va[i], vb[i], vc[i], vs[i]);
      wait_done(1'b0, lat, got, held);
      exp = q4.pop_front();
      checks++;
      if (got !== fixed[i] || got !== exp) begin
        failures++;
        $display("FAIL vector%0d: got %h required %h", i, got, fixed[i]);
      end
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL vector%0d_latency: got %0d required 4", i, lat);
      end
      @(negedge clk);
      checks++;
      if (bus4.o_done !== 1'b0) begin
        failures++;
        $display("FAIL vector%0d_done_width: done still %b, required 0", i, bus4.o_done);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t exp, got;
    int   lat;
    bit   held;
    issue(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus4.o_done) begin
        lat = i;
        break;
      end
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    got = observed(1'b0);
    exp = q4.pop_front();
    checks++;
    if (got !== exp || lat != 4) begin
      failures++;
      $display("FAIL b2b_first: got %h lat %0d required %h lat 4", got, lat, exp);
    end
    drive(1'b0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
    q4.push_back(model(16'h00FF, 16'h0F01, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (bus4.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: busy %b required 0", bus4.o_busy);
    end
    @(negedge clk);
    checks++;
    if (bus4.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_next_accept: busy %b required 1", bus4.o_busy);
    end
    drive(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, lat, got, held);
    exp = q4.pop_front();
    checks++;
    if (got !== exp || lat != 4) begin
      failures++;
      $display("FAIL b2b_second: got %h lat %0d required %h lat 4", got, lat, exp);
    end
    checks++;
    if (q4.size() != 0) begin
      failures++;
      $display("FAIL b2b_queue: %0d results pending, required 0", q4.size());
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    issue(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    q4.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.o_busy, bus4.o_done, observed(1'b0)} !== 20'd0) begin
      failures++;
      $display("FAIL abort_outputs: got %h required 0", {bus4.o_busy, bus4.o_done, observed(1'b0)});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.o_done) dones++;
    end
    checks++;
    if (dones != 0 || bus4.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: dones %0d busy %b required 0 0", dones, bus4.o_busy);
    end
  endtask

  task automatic test_full_digit;
    res_t exp, got;
    int   lat;
    bit   held;
    issue(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(1'b1, lat, got, held);
    exp = q16.pop_front();
    checks++;
    if (got !== {16'h5555, 1'b0, 1'b0} || got !== exp || lat != 1) begin
      failures++;
      $display("FAIL full_digit: got %h lat %0d required %h lat 1", got, lat, {16'h5555, 2'b00});
    end
  endtask

  task automatic test_random;
    res_t exp, got;
    int   lat;
    bit   held;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 250; n++) begin
        issue(s[0], 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_done(s[0], lat, got, held);
        exp = s[0] ? q16.pop_front() : q4.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL random_result dut%0d op%0d: got %h required %h", s, n, got, exp);
        end
        checks++;
        if (lat != (s[0] ? 1 : 4)) begin
          failures++;
          $display("FAIL random_latency dut%0d op%0d: got %0d required %0d", s, n, lat, s[0] ? 1 : 4);
        end
        checks++;
        if (!held) begin
          failures++;
          $display("FAIL random_hold dut%0d op%0d: outputs changed before done, required stable", s, n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_full_digit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
